// File: rtl/exec_unit.sv
// exec_unit: execute/writeback stage; single-cycle ALU plus optional shift-add multiplier.
// Define EXEC_MUL_EN to compile in the iterative multiplier (opcode 8).
module exec_unit #(
    parameter int RADDRWIDTH = 3,
    parameter int REGWIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            op,
    input  logic [RADDRWIDTH-1:0] rd,
    input  logic [REGWIDTH-1:0]   a,
    input  logic [REGWIDTH-1:0]   b,
    output logic                  we,
    output logic [RADDRWIDTH-1:0] waddr,
    output logic [REGWIDTH-1:0]   wdata,
    output logic                  busy,
    output logic                  illegal
);
    localparam int SW = $clog2(REGWIDTH);
    logic fire, is_mul, legal;
    logic [REGWIDTH-1:0] alu;
    assign fire = in_valid && in_ready;
    always_comb begin
        alu = '0;
        legal = 1'b1;
        case (op)
            4'd0: alu = a + b;
            4'd1: alu = a - b;
            4'd2: alu = a & b;
            4'd3: alu = a | b;
            4'd4: alu = a ^ b;
            4'd5: alu = a << b[SW-1:0];
            4'd6: alu = a >> b[SW-1:0];
            4'd7: alu = {{(REGWIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            default: legal = 1'b0;
        endcase
    end
`ifdef EXEC_MUL_EN
    typedef enum logic {IDLE, MUL} state_t;
    state_t state, state_n;
    logic [REGWIDTH-1:0] ma, mb, acc, sum;
    logic [RADDRWIDTH-1:0] mrd;
    logic [SW-1:0] cnt;
    logic mul_done;
    assign is_mul = op == 4'd8;
    assign in_ready = !rst && state == IDLE;
    assign busy = state == MUL;
    assign mul_done = state == MUL && cnt == SW'(REGWIDTH - 1);
    assign sum = acc + (mb[0] ? ma : '0);
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_n;
    always_comb begin
        state_n = state;
        if (state == IDLE && fire && is_mul) state_n = MUL;
        else if (mul_done) state_n = IDLE;
    end
    // multiplicand shifts left, multiplier shifts right; one bit per cycle
    always_ff @(posedge clk) begin
        if (fire && is_mul) begin
            ma <= a;
            mb <= b;
            acc <= '0;
            cnt <= '0;
            mrd <= rd;
        end else if (state == MUL) begin
            acc <= sum;
            ma <= ma << 1;
            mb <= mb >> 1;
            cnt <= cnt + SW'(1);
        end
    end
`else
    assign is_mul = 1'b0;
    assign in_ready = !rst;
    assign busy = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            we <= 1'b0;
            waddr <= '0;
            wdata <= '0;
            illegal <= 1'b0;
        end else begin
            we <= 1'b0;
            illegal <= 1'b0;
            if (fire && !is_mul) begin
                we <= legal && rd != '0;
                illegal <= !legal;
                waddr <= rd;
                wdata <= alu;
            end
`ifdef EXEC_MUL_EN
            if (mul_done) begin
                we <= mrd != '0;
                waddr <= mrd;
                wdata <= sum;
            end
`endif
        end
    end
endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: directed self-checking bench for exec_unit (both EXEC_MUL_EN builds).
module tb_exec_unit;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_ready;
    logic [3:0] op = '0;
    logic [2:0] rd = '0, waddr;
    logic [15:0] a = '0, b = '0, wdata;
    logic we, busy, illegal;
    int checks = 0, errors = 0;

    exec_unit dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rd(rd), .a(a), .b(b), .we(we), .waddr(waddr),
        .wdata(wdata), .busy(busy), .illegal(illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] o, input logic [2:0] r, input logic [15:0] x, input logic [15:0] y);
        in_valid = 1'b1;
        op = o;
        rd = r;
        a = x;
        b = y;
    endtask

    // single op with latency-1 result, then a check that the pulse lasts one cycle
    task automatic alu_op(input string tag, input logic [3:0] o, input logic [2:0] r,
                          input logic [15:0] x, input logic [15:0] y,
                          input logic ewe, input logic [15:0] ed, input logic eill);
        @(negedge clk);
        drive(o, r, x, y);
        chk({tag, " in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, " we"}, we, ewe);
        chk({tag, " illegal"}, illegal, eill);
        if (ewe) begin
            chk({tag, " waddr"}, waddr, r);
            chk({tag, " wdata"}, wdata, ed);
        end
        @(negedge clk);
        chk({tag, " we drop"}, we, 0);
        chk({tag, " illegal drop"}, illegal, 0);
    endtask

    initial begin
        int pulses;
        repeat (3) @(negedge clk);
        chk("rst in_ready", in_ready, 0);
        chk("rst we", we, 0);
        chk("rst waddr", waddr, 0);
        chk("rst wdata", wdata, 0);
        chk("rst busy", busy, 0);
        chk("rst illegal", illegal, 0);
        rst = 1'b0;
        #1 chk("post-rst in_ready", in_ready, 1);

        alu_op("add", 4'd0, 3'd3, 16'h7FFF, 16'h0001, 1, 16'h8000, 0);
        alu_op("sub", 4'd1, 3'd2, 16'h0000, 16'h0001, 1, 16'hFFFF, 0);
        alu_op("and", 4'd2, 3'd1, 16'hF0F0, 16'hFF00, 1, 16'hF000, 0);
        alu_op("or",  4'd3, 3'd1, 16'hF0F0, 16'hFF00, 1, 16'hFFF0, 0);
        alu_op("xor", 4'd4, 3'd1, 16'hF0F0, 16'hFF00, 1, 16'h0FF0, 0);
        alu_op("shl", 4'd5, 3'd4, 16'h0001, 16'h0014, 1, 16'h0010, 0);
        alu_op("shr", 4'd6, 3'd4, 16'h8000, 16'h0013, 1, 16'h1000, 0);
        alu_op("slt", 4'd7, 3'd7, 16'h8000, 16'h0001, 1, 16'h0001, 0);
        alu_op("slt0", 4'd7, 3'd7, 16'h0001, 16'h8000, 1, 16'h0000, 0);
        alu_op("illF", 4'hF, 3'd3, 16'h1234, 16'h5678, 0, 16'h0000, 1);
        alu_op("rd0", 4'd0, 3'd0, 16'h0001, 16'h0001, 0, 16'h0000, 0);

        @(negedge clk);
        drive(4'd0, 3'd1, 16'h0001, 16'h0010);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("b2b in_ready", in_ready, 1);
            chk("b2b we", we, 1);
            chk("b2b waddr", waddr, i);
            chk("b2b wdata", wdata, 16'h0010 + i);
            if (i < 4) drive(4'd0, 3'(i + 1), 16'(i + 1), 16'h0010);
            else in_valid = 1'b0;
        end
        @(negedge clk);
        chk("b2b end we", we, 0);

`ifdef EXEC_MUL_EN
        @(negedge clk);
        drive(4'd8, 3'd5, 16'h0123, 16'h0045);
        @(negedge clk);
        in_valid = 1'b0;
        chk("mul busy", busy, 1);
        chk("mul in_ready", in_ready, 0);
        for (int k = 1; k < 16; k++) begin
            @(negedge clk);
            chk("mul stall in_ready", in_ready, 0);
            chk("mul stall we", we, 0);
        end
        @(negedge clk);
        chk("mul we", we, 1);
        chk("mul waddr", waddr, 5);
        chk("mul wdata", wdata, 16'h4E6F);
        chk("mul done in_ready", in_ready, 1);
        chk("mul done busy", busy, 0);

        @(negedge clk);
        chk("mul we drop", we, 0);
        drive(4'd8, 3'd6, 16'hFFFF, 16'hFFFF);
        repeat (17) @(negedge clk);
        in_valid = 1'b0;
        chk("mulff we", we, 1);
        chk("mulff wdata", wdata, 16'h0001);

        @(negedge clk);
        drive(4'd8, 3'd6, 16'h0003, 16'h0003);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1 chk("abort in_ready", in_ready, 1);
        chk("abort busy", busy, 0);
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (we || illegal) pulses++;
        end
        chk("abort no write", pulses, 0);
        alu_op("add after abort", 4'd0, 3'd2, 16'h0002, 16'h0003, 1, 16'h0005, 0);
`else
        alu_op("mul illegal", 4'd8, 3'd5, 16'h0123, 16'h0045, 0, 16'h0000, 1);
        chk("nomul busy", busy, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
